// File: rtl/hcordic_pkg.sv
// Shared types and constants for the HCORDIC iteration controller.
// Float exponent slice and default convergence threshold live here.
package hcordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_CHECK    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic ROTATION  = 1'b1;
    localparam logic VECTORING = 1'b0;

    localparam logic [1:0] MODE_LINEAR     = 2'b00;
    localparam logic [1:0] MODE_CIRCULAR   = 2'b01;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

    localparam logic [7:0] CONV_EXP_DEFAULT = 8'h70;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;

    function automatic logic [7:0] float_exp(input logic [31:0] f);
        return f[EXP_MSB:EXP_LSB];
    endfunction

endpackage

// File: rtl/hcordic_conv_detect.sv
// Combinational convergence test: residual exponent (z for rotation,
// y for vectoring) at or below the threshold counts as converged.
module hcordic_conv_detect
    import hcordic_pkg::*;
(
    input  logic        operation,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [7:0]  threshold,
    output logic        converged
);

    logic [7:0] residual_exp;

    assign residual_exp = (operation == ROTATION) ? float_exp(z) : float_exp(y);

    // Zero/denormal is converged regardless of how the threshold is set.
    assign converged = (residual_exp == 8'h00) || (residual_exp <= threshold);

endmodule

// File: rtl/hcordic_iter_ctrl.sv
// Iteration controller and operand bank feeding the HCORDIC state-selection FSM.
// Define HCORDIC_ITER_TIMEOUT_EN to enforce the MAX_ITER limit and drive timeout.
module hcordic_iter_ctrl
    import hcordic_pkg::*;
#(
    parameter int         MAX_ITER = 32,
    parameter logic [7:0] CONV_EXP = CONV_EXP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        operation,
    input  logic [1:0]  mode,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    input  logic [31:0] k_in,
    input  logic [31:0] x_alu,
    input  logic [31:0] y_alu,
    input  logic [31:0] z_alu,
    input  logic [31:0] k_alu,
    input  logic        done_ALU,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] z,
    output logic [31:0] k,
    output logic        op_out,
    output logic [1:0]  mode_out,
    output logic        busy,
    output logic [7:0]  iter_count,
    output logic        result_valid,
    output logic        timeout
);

    state_e state;
    logic   converged;
    logic   limit_hit;

    hcordic_conv_detect u_conv (
        .operation (op_out),
        .y         (y),
        .z         (z),
        .threshold (CONV_EXP),
        .converged (converged)
    );

`ifdef HCORDIC_ITER_TIMEOUT_EN
    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

    assign limit_hit = (iter_count == ITER_LIMIT);

    // Convergence wins over the limit when both happen on the same check.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            timeout <= 1'b0;
        end else if (state == ST_CHECK && !converged && limit_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            x            <= '0;
            y            <= '0;
            z            <= '0;
            k            <= '0;
            op_out       <= 1'b0;
            mode_out     <= 2'b00;
            busy         <= 1'b0;
            iter_count   <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x          <= x_in;
                        y          <= y_in;
                        z          <= z_in;
                        k          <= k_in;
                        op_out     <= operation;
                        mode_out   <= mode;
                        iter_count <= '0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (converged) begin
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_ALU;
                    end
                end
                ST_WAIT_ALU: begin
                    if (done_ALU) begin
                        x <= x_alu;
                        y <= y_alu;
                        z <= z_alu;
                        k <= k_alu;
                        if (iter_count != 8'hFF) begin
                            iter_count <= iter_count + 8'd1;
                        end
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (converged || limit_hit) begin
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_ALU;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcordic_iter_ctrl.sv
// Directed self-checking bench for hcordic_iter_ctrl (MAX_ITER = 4).
// Timeout expectations follow HCORDIC_ITER_TIMEOUT_EN.
module tb_hcordic_iter_ctrl;
    import hcordic_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        operation;
    logic [1:0]  mode;
    logic [31:0] x_in, y_in, z_in, k_in;
    logic [31:0] x_alu, y_alu, z_alu, k_alu;
    logic        done_ALU;
    logic [31:0] x, y, z, k;
    logic        op_out;
    logic [1:0]  mode_out;
    logic        busy;
    logic [7:0]  iter_count;
    logic        result_valid;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;

    hcordic_iter_ctrl #(
        .MAX_ITER (4),
        .CONV_EXP (8'h70)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .operation    (operation),
        .mode         (mode),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .k_in         (k_in),
        .x_alu        (x_alu),
        .y_alu        (y_alu),
        .z_alu        (z_alu),
        .k_alu        (k_alu),
        .done_ALU     (done_ALU),
        .x            (x),
        .y            (y),
        .z            (z),
        .k            (k),
        .op_out       (op_out),
        .mode_out     (mode_out),
        .busy         (busy),
        .iter_count   (iter_count),
        .result_valid (result_valid),
        .timeout      (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic op, input logic [1:0] md,
                                 input logic [31:0] xv, input logic [31:0] yv,
                                 input logic [31:0] zv, input logic [31:0] kv);
        operation = op;
        mode      = md;
        x_in      = xv;
        y_in      = yv;
        z_in      = zv;
        k_in      = kv;
        start     = 1'b1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_x"}, x, 32'h0);
        checkOutput({tag, "_y"}, y, 32'h0);
        checkOutput({tag, "_z"}, z, 32'h0);
        checkOutput({tag, "_k"}, k, 32'h0);
        checkOutput({tag, "_op"}, {31'h0, op_out}, 32'h0);
        checkOutput({tag, "_mode"}, {30'h0, mode_out}, 32'h0);
        checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
        checkOutput({tag, "_iter"}, {24'h0, iter_count}, 32'h0);
        checkOutput({tag, "_rv"}, {31'h0, result_valid}, 32'h0);
        checkOutput({tag, "_tmo"}, {31'h0, timeout}, 32'h0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        operation = 1'b0;
        mode      = 2'b00;
        x_in = '0; y_in = '0; z_in = '0; k_in = '0;
        x_alu = '0; y_alu = '0; z_alu = '0; k_alu = '0;
        done_ALU  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkReset("reset");
        reset_n = 1'b1;

        $display("[TB] rotation, one iteration to converge");
        applyStimulus(ROTATION, MODE_CIRCULAR, 32'h3F800000, 32'h00000000,
                      32'h3A000000, 32'h3F1B74EE);
        tick;
        start = 1'b0;
        checkOutput("a_busy", {31'h0, busy}, 32'h1);
        checkOutput("a_z", z, 32'h3A000000);
        checkOutput("a_x", x, 32'h3F800000);
        checkOutput("a_k", k, 32'h3F1B74EE);
        checkOutput("a_op", {31'h0, op_out}, 32'h1);
        checkOutput("a_mode", {30'h0, mode_out}, 32'h1);
        checkOutput("a_iter0", {24'h0, iter_count}, 32'h0);
        tick;
        checkOutput("a_load_rv", {31'h0, result_valid}, 32'h0);
        tick;
        checkOutput("a_wait_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("a_wait_busy", {31'h0, busy}, 32'h1);
        x_alu = 32'h3F000000; y_alu = 32'h3E800000;
        z_alu = 32'h37000000; k_alu = 32'h3F1B74EE;
        done_ALU = 1'b1;
        tick;
        done_ALU = 1'b0;
        checkOutput("a_chk_z", z, 32'h37000000);
        checkOutput("a_chk_x", x, 32'h3F000000);
        checkOutput("a_chk_iter", {24'h0, iter_count}, 32'h1);
        checkOutput("a_chk_rv", {31'h0, result_valid}, 32'h0);
        tick;
        checkOutput("a_done_rv", {31'h0, result_valid}, 32'h1);
        checkOutput("a_done_tmo", {31'h0, timeout}, 32'h0);
        checkOutput("a_done_iter", {24'h0, iter_count}, 32'h1);
        checkOutput("a_done_z", z, 32'h37000000);
        checkOutput("a_done_busy", {31'h0, busy}, 32'h1);
        tick;
        checkOutput("a_idle_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("a_idle_busy", {31'h0, busy}, 32'h0);
        checkOutput("a_idle_z", z, 32'h37000000);

        $display("[TB] rotation, already converged at start");
        applyStimulus(ROTATION, MODE_LINEAR, 32'h40000000, 32'h3F800000,
                      32'h00000000, 32'h3F800000);
        tick;
        start = 1'b0;
        checkOutput("b_busy", {31'h0, busy}, 32'h1);
        checkOutput("b_load_rv", {31'h0, result_valid}, 32'h0);
        tick;
        checkOutput("b_done_rv", {31'h0, result_valid}, 32'h1);
        checkOutput("b_done_iter", {24'h0, iter_count}, 32'h0);
        checkOutput("b_done_tmo", {31'h0, timeout}, 32'h0);
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("b_idle_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("b_idle_busy", {31'h0, busy}, 32'h0);
        tick;
        checkOutput("b_done_start_ignored", {31'h0, busy}, 32'h0);

        $display("[TB] stray done_ALU in IDLE");
        x_alu = 32'h12345678; z_alu = 32'h3F800000;
        done_ALU = 1'b1;
        tick;
        done_ALU = 1'b0;
        checkOutput("c_iter", {24'h0, iter_count}, 32'h0);
        checkOutput("c_x", x, 32'h40000000);
        checkOutput("c_z", z, 32'h00000000);
        checkOutput("c_busy", {31'h0, busy}, 32'h0);

        $display("[TB] vectoring, never converging");
        applyStimulus(VECTORING, MODE_HYPERBOLIC, 32'h3F800000, 32'h3F000000,
                      32'h00000000, 32'h3F800000);
        tick;
        start = 1'b0;
        checkOutput("d_busy", {31'h0, busy}, 32'h1);
        checkOutput("d_y", y, 32'h3F000000);
        checkOutput("d_op", {31'h0, op_out}, 32'h0);
        checkOutput("d_mode", {30'h0, mode_out}, 32'h3);
        tick;
        checkOutput("d_load_rv", {31'h0, result_valid}, 32'h0);
        x_alu = 32'h3F800000; y_alu = 32'h3F000000;
        z_alu = 32'h00000000; k_alu = 32'h3F800000;
        done_ALU = 1'b1;
        tick;
        applyStimulus(ROTATION, MODE_LINEAR, 32'hDEADBEEF, 32'h0,
                      32'h0, 32'h0);
        tick;
        done_ALU = 1'b0;
        start    = 1'b0;
        checkOutput("d_iter1", {24'h0, iter_count}, 32'h1);
        checkOutput("d_it1_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("d_it1_x", x, 32'h3F800000);
        checkOutput("d_it1_op", {31'h0, op_out}, 32'h0);
        for (int i = 2; i <= 3; i++) begin
            done_ALU = 1'b1;
            tick;
            done_ALU = 1'b0;
            checkOutput("d_iter", {24'h0, iter_count}, i);
            tick;
            checkOutput("d_iter_rv", {31'h0, result_valid}, 32'h0);
        end
        done_ALU = 1'b1;
        tick;
        done_ALU = 1'b0;
        checkOutput("d_iter4", {24'h0, iter_count}, 32'h4);
        tick;
`ifdef HCORDIC_ITER_TIMEOUT_EN
        checkOutput("d_tmo_rv", {31'h0, result_valid}, 32'h1);
        checkOutput("d_tmo", {31'h0, timeout}, 32'h1);
        checkOutput("d_tmo_iter", {24'h0, iter_count}, 32'h4);
        tick;
        checkOutput("d_tmo_idle_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("d_tmo_idle_busy", {31'h0, busy}, 32'h0);
`else
        checkOutput("d_nolimit_rv", {31'h0, result_valid}, 32'h0);
        checkOutput("d_nolimit_busy", {31'h0, busy}, 32'h1);
        checkOutput("d_nolimit_tmo", {31'h0, timeout}, 32'h0);
        y_alu = 32'h00000000;
        done_ALU = 1'b1;
        tick;
        done_ALU = 1'b0;
        checkOutput("d_iter5", {24'h0, iter_count}, 32'h5);
        tick;
        checkOutput("d_conv_rv", {31'h0, result_valid}, 32'h1);
        checkOutput("d_conv_tmo", {31'h0, timeout}, 32'h0);
        tick;
        checkOutput("d_conv_idle_busy", {31'h0, busy}, 32'h0);
`endif

        $display("[TB] reset in WAIT_ALU after three iterations");
        applyStimulus(ROTATION, MODE_CIRCULAR, 32'h3F800000, 32'h00000000,
                      32'h3F800000, 32'h3F800000);
        tick;
        start = 1'b0;
        tick;
        x_alu = 32'h3F800000; y_alu = 32'h00000000;
        z_alu = 32'h3F800000; k_alu = 32'h3F800000;
        for (int i = 1; i <= 3; i++) begin
            done_ALU = 1'b1;
            tick;
            done_ALU = 1'b0;
            tick;
        end
        checkOutput("e_iter3", {24'h0, iter_count}, 32'h3);
        checkOutput("e_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        checkReset("e_reset");
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("e_hold_rv", {31'h0, result_valid}, 32'h0);
        end
        reset_n = 1'b1;
        tick;
        checkOutput("e_after_busy", {31'h0, busy}, 32'h0);
        checkOutput("e_after_rv", {31'h0, result_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
